// File: rtl/clk_div_prog.sv
// Programmable clock divider: divides clk_i by a runtime-loadable N, producing a
// near-50% duty clk_o and a one-cycle tick_o at each period start.
//
// Divisor handshake: div_i is transferred on any rising clk_i edge where
// div_vld_i & div_rdy_o. div_rdy_o is ~pend, so only one update is ever held.
// A held update is applied at the next enabled wrap or clear. div_rdy_o rises
// on the cycle after the apply.
module clk_div_prog #(
    parameter int CNT_W    = 16,
    parameter int DIV_INIT = 1000
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic [CNT_W-1:0] div_i,
    input  logic             div_vld_i,
    output logic             div_rdy_o,
    output logic             div_err_o,
    output logic             clk_o,
    output logic             tick_o
);

    localparam logic [CNT_W-1:0] L_DIV_INIT = CNT_W'(DIV_INIT);
    localparam logic [CNT_W-1:0] L_HI_INIT  = L_DIV_INIT - (L_DIV_INIT >> 1);
    localparam logic [CNT_W-1:0] L_ONE      = CNT_W'(1);

    logic [CNT_W-1:0] r_div_act;
    logic [CNT_W-1:0] r_hi_act;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_div_pend;
    logic             r_pend;
    logic             r_clk;
    logic             r_tick;
    logic             r_err;

    logic             w_wrap;
    logic             w_xfer;
    logic             w_legal;
    logic             w_apply;
    logic [CNT_W-1:0] w_div_nxt;
    logic [CNT_W-1:0] w_hi_nxt;
    logic [CNT_W-1:0] w_hi_use;
    logic [CNT_W-1:0] w_cnt_n;

    always_comb begin
        w_wrap    = (r_cnt == (r_div_act - L_ONE));
        w_xfer    = div_vld_i & ~r_pend;
        w_legal   = (div_i >= CNT_W'(2));
        // Divisor in force after this edge if a pending update gets applied now.
        w_div_nxt = r_pend ? r_div_pend : r_div_act;
        w_hi_nxt  = w_div_nxt - (w_div_nxt >> 1);
        w_apply   = r_pend & (clr_i | (en_i & w_wrap));
        w_cnt_n   = w_wrap ? '0 : (r_cnt + L_ONE);
        // The period starting on a wrap edge already uses the new high time.
        w_hi_use  = (w_wrap && r_pend) ? w_hi_nxt : r_hi_act;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_div_act <= L_DIV_INIT;
            r_hi_act  <= L_HI_INIT;
            r_cnt     <= L_DIV_INIT - L_ONE;
            r_clk     <= 1'b0;
            r_tick    <= 1'b0;
        end else if (clr_i) begin
            r_div_act <= w_div_nxt;
            r_hi_act  <= w_hi_nxt;
            r_cnt     <= w_div_nxt - L_ONE;
            r_clk     <= 1'b0;
            r_tick    <= 1'b0;
        end else if (en_i) begin
            if (w_wrap) begin
                r_div_act <= w_div_nxt;
                r_hi_act  <= w_hi_nxt;
            end
            r_cnt  <= w_cnt_n;
            r_clk  <= (w_cnt_n < w_hi_use);
            r_tick <= (w_cnt_n == '0);
        end else begin
            r_tick <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_div_pend <= '0;
            r_pend     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_err <= w_xfer & ~w_legal;
            if (w_apply) begin
                r_pend <= 1'b0;
            end else if (w_xfer && w_legal) begin
                r_div_pend <= div_i;
                r_pend     <= 1'b1;
            end
        end
    end

    assign div_rdy_o = ~r_pend;
    assign div_err_o = r_err;
    assign clk_o     = r_clk;
    assign tick_o    = r_tick;

endmodule

// File: tb/tb_clk_div_prog.sv
// Directed bench for clk_div_prog with DIV_INIT=4: period shape, divisor updates,
// illegal divisors, freeze, clear and asynchronous reset with a pending update.
module tb_clk_div_prog;

    localparam int CNT_W = 8;

    logic             clk_i;
    logic             rst_n_i;
    logic             en_i;
    logic             clr_i;
    logic [CNT_W-1:0] div_i;
    logic             div_vld_i;
    logic             div_rdy_o;
    logic             div_err_o;
    logic             clk_o;
    logic             tick_o;

    int errors = 0;
    int checks = 0;

    clk_div_prog #(.CNT_W(CNT_W), .DIV_INIT(4)) dut (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .en_i      (en_i),
        .clr_i     (clr_i),
        .div_i     (div_i),
        .div_vld_i (div_vld_i),
        .div_rdy_o (div_rdy_o),
        .div_err_o (div_err_o),
        .clk_o     (clk_o),
        .tick_o    (tick_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Step n cycles; expected patterns are MSB-first (first cycle = bit n-1).
    task automatic run_seq(input string tag, input int n,
                           input logic [31:0] exp_clk, input logic [31:0] exp_tick,
                           input logic exp_rdy);
        for (int i = 0; i < n; i++) begin
            step();
            chk($sformatf("%s_clk%0d", tag, i), clk_o, exp_clk[n-1-i]);
            chk($sformatf("%s_tick%0d", tag, i), tick_o, exp_tick[n-1-i]);
            chk($sformatf("%s_rdy%0d", tag, i), div_rdy_o, exp_rdy);
            chk($sformatf("%s_err%0d", tag, i), div_err_o, 1'b0);
        end
    endtask

    initial begin
        rst_n_i   = 1'b0;
        en_i      = 1'b0;
        clr_i     = 1'b0;
        div_i     = '0;
        div_vld_i = 1'b0;

        #12;
        chk("rst_clk", clk_o, 1'b0);
        chk("rst_tick", tick_o, 1'b0);
        chk("rst_err", div_err_o, 1'b0);
        chk("rst_rdy", div_rdy_o, 1'b1);

        // 1: N=4 from reset, first enabled edge starts a period
        @(posedge clk_i); #1;
        rst_n_i = 1'b1;
        en_i    = 1'b1;
        run_seq("t1", 8, 32'b11001100, 32'b10001000, 1'b1);

        // 2: load N=5 at the wrap edge; it applies at the following wrap
        div_i = 8'd5; div_vld_i = 1'b1;
        step();
        div_vld_i = 1'b0;
        chk("t2_wrap_clk", clk_o, 1'b1);
        chk("t2_wrap_tick", tick_o, 1'b1);
        chk("t2_rdy_low", div_rdy_o, 1'b0);
        run_seq("t2_old", 3, 32'b100, 32'b000, 1'b0);
        step();
        chk("t2_apply_clk", clk_o, 1'b1);
        chk("t2_apply_tick", tick_o, 1'b1);
        chk("t2_apply_rdy", div_rdy_o, 1'b1);
        run_seq("t2_new", 9, 32'b110011100, 32'b000010000, 1'b1);

        // load N=4 and apply it through a clear
        div_i = 8'd4; div_vld_i = 1'b1;
        step();
        div_vld_i = 1'b0;
        chk("t3_ld_tick", tick_o, 1'b1);
        chk("t3_ld_rdy", div_rdy_o, 1'b0);
        clr_i = 1'b1;
        step();
        clr_i = 1'b0;
        chk("t3_clr_clk", clk_o, 1'b0);
        chk("t3_clr_tick", tick_o, 1'b0);
        chk("t3_clr_rdy", div_rdy_o, 1'b1);
        run_seq("t3_n4", 2, 32'b11, 32'b10, 1'b1);

        // 3: write N=6 at cnt=1; current 4-cycle period completes first
        div_i = 8'd6; div_vld_i = 1'b1;
        step();
        div_vld_i = 1'b0;
        chk("t3_wr_clk", clk_o, 1'b0);
        chk("t3_wr_rdy", div_rdy_o, 1'b0);
        run_seq("t3_tail", 1, 32'b0, 32'b0, 1'b0);
        step();
        chk("t3_apply_tick", tick_o, 1'b1);
        chk("t3_apply_clk", clk_o, 1'b1);
        chk("t3_apply_rdy", div_rdy_o, 1'b1);
        run_seq("t3_n6", 6, 32'b110001, 32'b000001, 1'b1);

        // 4: illegal divisors 1 and 0 pulse div_err_o and change nothing
        div_i = 8'd1; div_vld_i = 1'b1;
        step();
        div_vld_i = 1'b0;
        chk("t4_err1", div_err_o, 1'b1);
        chk("t4_err1_rdy", div_rdy_o, 1'b1);
        chk("t4_err1_clk", clk_o, 1'b1);
        step();
        chk("t4_err1_end", div_err_o, 1'b0);
        chk("t4_gap_clk", clk_o, 1'b1);
        div_i = 8'd0; div_vld_i = 1'b1;
        step();
        div_vld_i = 1'b0;
        chk("t4_err0", div_err_o, 1'b1);
        chk("t4_err0_rdy", div_rdy_o, 1'b1);
        chk("t4_err0_clk", clk_o, 1'b0);
        run_seq("t4_rest", 3, 32'b001, 32'b001, 1'b1);

        // 5: freeze 3 cycles while clk_o=1 stretches the period to 9
        en_i = 1'b0;
        run_seq("t5_frz", 3, 32'b111, 32'b000, 1'b1);
        en_i = 1'b1;
        run_seq("t5_run", 6, 32'b110001, 32'b000001, 1'b1);
        run_seq("t5_pre", 1, 32'b1, 32'b0, 1'b1);
        clr_i = 1'b1;
        run_seq("t5_clr", 1, 32'b0, 32'b0, 1'b1);
        clr_i = 1'b0;
        run_seq("t5_post", 1, 32'b1, 32'b1, 1'b1);

        // 6: async reset mid-period with N=3 pending; pending value is lost
        div_i = 8'd3; div_vld_i = 1'b1;
        step();
        div_vld_i = 1'b0;
        chk("t6_pend_rdy", div_rdy_o, 1'b0);
        step();
        chk("t6_pre_clk", clk_o, 1'b1);
        #2;
        rst_n_i = 1'b0;
        #1;
        chk("t6_async_clk", clk_o, 1'b0);
        chk("t6_async_tick", tick_o, 1'b0);
        chk("t6_async_rdy", div_rdy_o, 1'b1);
        chk("t6_async_err", div_err_o, 1'b0);
        step();
        rst_n_i = 1'b1;
        run_seq("t6_init", 8, 32'b11001100, 32'b10001000, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
